// File: rtl/wb_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter.
// WB_ARB_RR_EN (see wb_arbiter) selects round-robin instead of fixed mem-over-alu priority.
package wb_arbiter_pkg;

   localparam int XLEN_DEF = 64;
   localparam int RW_DEF   = 5;
   localparam int NREGS    = 32;

   typedef enum logic {
      SRC_MEM = 1'b0,
      SRC_ALU = 1'b1
   } src_e;

   typedef struct packed {
      logic [RW_DEF-1:0]   rd;
      logic [XLEN_DEF-1:0] value;
   } wb_req_t;

   // Register zero is never a real destination, so it never marks a hazard.
   function automatic logic [NREGS-1:0] rd_bit(input logic [RW_DEF-1:0] rd);
      logic [NREGS-1:0] mask;
      mask    = NREGS'(1) << rd;
      mask[0] = 1'b0;
      return mask;
   endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding register for a write-back source that lost arbitration.
// Capture has priority over free; the two are never asserted together by the arbiter.
module wb_hold_slot
   import wb_arbiter_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int RW   = RW_DEF
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            capture,
   input  logic            free,
   input  logic [RW-1:0]   cap_rd,
   input  logic [XLEN-1:0] cap_value,
   output logic            occupied,
   output logic            ready,
   output logic [RW-1:0]   held_rd,
   output logic [XLEN-1:0] held_value
);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         occupied   <= 1'b0;
         held_rd    <= '0;
         held_value <= '0;
      end else if (capture) begin
         occupied   <= 1'b1;
         held_rd    <= cap_rd;
         held_value <= cap_value;
      end else if (free) begin
         occupied   <= 1'b0;
      end
   end

   assign ready = ~occupied;

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU and load stages.
// Define WB_ARB_RR_EN for round-robin on conflicts; otherwise mem always beats alu.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int RW   = RW_DEF
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            alu_valid,
   input  logic [RW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_value,
   output logic            alu_ready,
   input  logic            mem_valid,
   input  logic [RW-1:0]   mem_rd,
   input  logic [XLEN-1:0] mem_value,
   output logic            mem_ready,
   output logic            wb_en,
   output logic [RW-1:0]   wb_rd,
   output logic [XLEN-1:0] wb_value,
   output logic [31:0]     pending_mask,
   output logic [15:0]     conflict_cnt
);

   logic            alu_occ, mem_occ;
   logic [RW-1:0]   alu_held_rd, mem_held_rd;
   logic [XLEN-1:0] alu_held_value, mem_held_value;

   logic            alu_live, mem_live;
   logic            alu_cand, mem_cand;
   logic [RW-1:0]   alu_cand_rd, mem_cand_rd;
   logic [XLEN-1:0] alu_cand_value, mem_cand_value;
   logic            both, same_rd, any_cand;
   src_e            grant, favour;
   logic [RW-1:0]   win_rd;
   logic [XLEN-1:0] win_value;
   logic            alu_capture, mem_capture, alu_free, mem_free;

   wb_hold_slot #(.XLEN(XLEN), .RW(RW)) u_alu_slot (
      .CLK        (CLK),
      .reset      (reset),
      .capture    (alu_capture),
      .free       (alu_free),
      .cap_rd     (alu_rd),
      .cap_value  (alu_value),
      .occupied   (alu_occ),
      .ready      (alu_ready),
      .held_rd    (alu_held_rd),
      .held_value (alu_held_value)
   );

   wb_hold_slot #(.XLEN(XLEN), .RW(RW)) u_mem_slot (
      .CLK        (CLK),
      .reset      (reset),
      .capture    (mem_capture),
      .free       (mem_free),
      .cap_rd     (mem_rd),
      .cap_value  (mem_value),
      .occupied   (mem_occ),
      .ready      (mem_ready),
      .held_rd    (mem_held_rd),
      .held_value (mem_held_value)
   );

   // A live input only counts while its slot is empty; otherwise the held entry is older.
   assign alu_live       = alu_valid & ~alu_occ;
   assign mem_live       = mem_valid & ~mem_occ;
   assign alu_cand       = alu_occ | alu_valid;
   assign mem_cand       = mem_occ | mem_valid;
   assign alu_cand_rd    = alu_occ ? alu_held_rd    : alu_rd;
   assign alu_cand_value = alu_occ ? alu_held_value : alu_value;
   assign mem_cand_rd    = mem_occ ? mem_held_rd    : mem_rd;
   assign mem_cand_value = mem_occ ? mem_held_value : mem_value;
   assign both           = alu_cand & mem_cand;
   assign same_rd        = both & (alu_cand_rd == mem_cand_rd);
   assign any_cand       = alu_cand | mem_cand;

`ifdef WB_ARB_RR_EN
   src_e last_grant;

   // Reset to alu so the first conflict goes to mem.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         last_grant <= SRC_ALU;
      end else if (both) begin
         last_grant <= grant;
      end
   end

   assign favour = (last_grant == SRC_MEM) ? SRC_ALU : SRC_MEM;
`else
   assign favour = SRC_MEM;
`endif

   always_comb begin
      grant     = SRC_MEM;
      win_rd    = mem_cand_rd;
      win_value = mem_cand_value;
      if (both) begin
         // Equal destinations must retire in program order, and mem is the older one.
         grant = same_rd ? SRC_MEM : favour;
      end else if (alu_cand) begin
         grant = SRC_ALU;
      end
      if (grant == SRC_ALU) begin
         win_rd    = alu_cand_rd;
         win_value = alu_cand_value;
      end
   end

   assign alu_capture = alu_live & (grant != SRC_ALU);
   assign mem_capture = mem_live & (grant != SRC_MEM);
   assign alu_free    = alu_occ  & (grant == SRC_ALU);
   assign mem_free    = mem_occ  & (grant == SRC_MEM);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         wb_en    <= 1'b0;
         wb_rd    <= '0;
         wb_value <= '0;
      end else if (any_cand) begin
         wb_en    <= (win_rd != '0);
         wb_rd    <= win_rd;
         wb_value <= win_value;
      end else begin
         wb_en    <= 1'b0;
      end
   end

   always_comb begin
      pending_mask = '0;
      if (alu_occ) pending_mask = pending_mask | rd_bit(alu_held_rd);
      if (mem_occ) pending_mask = pending_mask | rd_bit(mem_held_rd);
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         conflict_cnt <= '0;
      end else if (both && (conflict_cnt != 16'hFFFF)) begin
         conflict_cnt <= conflict_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scoreboard bench for wb_arbiter; expected writes carry the cycle they are due.
// Expectations follow WB_ARB_RR_EN when the bench is built with it.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   localparam int XLEN = 64;
   localparam int RW   = 5;

   logic            CLK = 1'b0;
   logic            reset;
   logic            alu_valid, mem_valid;
   logic [RW-1:0]   alu_rd, mem_rd;
   logic [XLEN-1:0] alu_value, mem_value;
   logic            alu_ready, mem_ready;
   logic            wb_en;
   logic [RW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_value;
   logic [31:0]     pending_mask;
   logic [15:0]     conflict_cnt;

   always #5 CLK = ~CLK;

   wb_arbiter #(.XLEN(XLEN), .RW(RW)) dut (
      .CLK          (CLK),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_value    (alu_value),
      .alu_ready    (alu_ready),
      .mem_valid    (mem_valid),
      .mem_rd       (mem_rd),
      .mem_value    (mem_value),
      .mem_ready    (mem_ready),
      .wb_en        (wb_en),
      .wb_rd        (wb_rd),
      .wb_value     (wb_value),
      .pending_mask (pending_mask),
      .conflict_cnt (conflict_cnt)
   );

   typedef struct {
      int      due;
      wb_req_t req;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   exp_cnt = 0;
   int   ai, mi, s;
   logic acc_a, acc_m;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic push(input int due, input logic [4:0] rd, input logic [63:0] value);
      exp_t e;
      e.due       = due;
      e.req.rd    = rd;
      e.req.value = value;
      sb.push_back(e);
   endtask

   task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] aval,
                        input logic mv, input logic [4:0] mrd, input logic [63:0] mval);
      alu_valid = av;
      alu_rd    = ard;
      alu_value = aval;
      mem_valid = mv;
      mem_rd    = mrd;
      mem_value = mval;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
   endtask

   // Advance one edge and compare the write port against the scoreboard head.
   task automatic tick();
      exp_t e;
      @(posedge CLK);
      cyc++;
      #1;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk("wb_en", 64'(wb_en), 64'd1);
         chk("wb_rd", 64'(wb_rd), 64'(e.req.rd));
         chk("wb_value", wb_value, e.req.value);
      end else begin
         chk("wb_en_idle", 64'(wb_en), 64'd0);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      #12;
      chk("rst_wb_en", 64'(wb_en), 64'd0);
      chk("rst_wb_rd", 64'(wb_rd), 64'd0);
      chk("rst_wb_value", wb_value, 64'd0);
      chk("rst_mask", 64'(pending_mask), 64'd0);
      chk("rst_cnt", 64'(conflict_cnt), 64'd0);
      chk("rst_alu_ready", 64'(alu_ready), 64'd1);
      chk("rst_mem_ready", 64'(mem_ready), 64'd1);
      reset = 1'b0;
      tick();

      // ALU only
      drive(1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 64'd0);
      push(cyc + 1, 5'd3, 64'h11);
      @(negedge CLK);
      chk("alu_only_ready", 64'(alu_ready), 64'd1);
      tick();
      idle();
      @(negedge CLK);
      chk("alu_only_ready_after", 64'(alu_ready), 64'd1);
      tick();

      // Collision on distinct destinations
      drive(1'b1, 5'd6, 64'hBB, 1'b1, 5'd5, 64'hAA);
      push(cyc + 1, 5'd5, 64'hAA);
      push(cyc + 2, 5'd6, 64'hBB);
      @(negedge CLK);
      chk("coll_alu_ready0", 64'(alu_ready), 64'd1);
      chk("coll_mask0", 64'(pending_mask), 64'd0);
      tick();
      exp_cnt = 1;
      idle();
      @(negedge CLK);
      chk("coll_alu_ready1", 64'(alu_ready), 64'd0);
      chk("coll_mem_ready1", 64'(mem_ready), 64'd1);
      chk("coll_mask1", 64'(pending_mask), 64'h40);
      tick();
      @(negedge CLK);
      chk("coll_alu_ready2", 64'(alu_ready), 64'd1);
      chk("coll_mask2", 64'(pending_mask), 64'd0);
      chk("coll_cnt", 64'(conflict_cnt), 64'(exp_cnt));
      tick();

      // Same destination: mem first even when round-robin would favour alu
      drive(1'b1, 5'd7, 64'h2, 1'b1, 5'd7, 64'h1);
      push(cyc + 1, 5'd7, 64'h1);
      push(cyc + 2, 5'd7, 64'h2);
      tick();
      exp_cnt++;
      idle();
      @(negedge CLK);
      chk("same_rd_mask", 64'(pending_mask), 64'h80);
      tick();
      chk("same_rd_cnt", 64'(conflict_cnt), 64'(exp_cnt));
      chk("same_rd_drained", 64'(sb.size()), 64'd0);

      // rd 0 alone: accepted, no write, no pending bit
      drive(1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, 64'd0);
      @(negedge CLK);
      chk("rd0_ready", 64'(alu_ready), 64'd1);
      tick();
      idle();
      @(negedge CLK);
      chk("rd0_mask", 64'(pending_mask), 64'd0);
      chk("rd0_ready_after", 64'(alu_ready), 64'd1);
      tick();

      // rd 0 colliding with a real write
      drive(1'b1, 5'd0, 64'h55, 1'b1, 5'd4, 64'h44);
`ifdef WB_ARB_RR_EN
      push(cyc + 2, 5'd4, 64'h44);
`else
      push(cyc + 1, 5'd4, 64'h44);
`endif
      tick();
      exp_cnt++;
      idle();
      @(negedge CLK);
`ifdef WB_ARB_RR_EN
      chk("rd0_coll_mask", 64'(pending_mask), 64'h10);
      chk("rd0_coll_mem_ready", 64'(mem_ready), 64'd0);
`else
      chk("rd0_coll_mask", 64'(pending_mask), 64'd0);
      chk("rd0_coll_alu_ready", 64'(alu_ready), 64'd0);
`endif
      tick();
      chk("rd0_coll_cnt", 64'(conflict_cnt), 64'(exp_cnt));

      // Sustained: both producers offer 8 results back to back
      s = cyc + 1;
      for (int k = 0; k < 8; k++) begin
`ifdef WB_ARB_RR_EN
         push(s + 2 * k,     5'(24 + k), 64'hB000 + 64'(k));
         push(s + 2 * k + 1, 5'(16 + k), 64'hA000 + 64'(k));
`else
         push(s + k,     5'(24 + k), 64'hB000 + 64'(k));
         push(s + 8 + k, 5'(16 + k), 64'hA000 + 64'(k));
`endif
      end
      sb.sort() with (item.due);
      ai = 0;
      mi = 0;
      for (int n = 0; n < 40 && (ai < 8 || mi < 8 || sb.size() > 0); n++) begin
         drive(ai < 8, 5'(16 + ai), 64'hA000 + 64'(ai), mi < 8, 5'(24 + mi), 64'hB000 + 64'(mi));
         @(negedge CLK);
         acc_a = alu_valid & alu_ready;
         acc_m = mem_valid & mem_ready;
         tick();
         if (acc_a) ai++;
         if (acc_m) mi++;
      end
      idle();
`ifdef WB_ARB_RR_EN
      exp_cnt += 15;
`else
      exp_cnt += 8;
`endif
      chk("sust_drained", 64'(sb.size()), 64'd0);
      chk("sust_alu_all", 64'(ai), 64'd8);
      chk("sust_mem_all", 64'(mi), 64'd8);
      chk("sust_cnt", 64'(conflict_cnt), 64'(exp_cnt));

      // Reset while alu rd 9 is held
      drive(1'b1, 5'd9, 64'h77, 1'b1, 5'd9, 64'h99);
      push(cyc + 1, 5'd9, 64'h99);
      tick();
      idle();
      @(negedge CLK);
      chk("hold9_mask", 64'(pending_mask), 64'h200);
      chk("hold9_alu_ready", 64'(alu_ready), 64'd0);
      #1 reset = 1'b1;
      #1;
      chk("midrst_wb_en", 64'(wb_en), 64'd0);
      chk("midrst_wb_rd", 64'(wb_rd), 64'd0);
      chk("midrst_wb_value", wb_value, 64'd0);
      chk("midrst_mask", 64'(pending_mask), 64'd0);
      chk("midrst_cnt", 64'(conflict_cnt), 64'd0);
      chk("midrst_alu_ready", 64'(alu_ready), 64'd1);
      chk("midrst_mem_ready", 64'(mem_ready), 64'd1);
      sb.delete();
      #1 reset = 1'b0;
      for (int n = 0; n < 3; n++) tick();
      chk("postrst_mask", 64'(pending_mask), 64'd0);
      chk("postrst_cnt", 64'(conflict_cnt), 64'd0);
      chk("final_drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
